// File: rtl/inst_mem_pkg.sv
// Package: inst_mem_pkg
// Shared definitions for the instruction-memory loader slice:
//   state_t           loader FSM states (IDLE/LOAD/DRAIN/RUN)
//   NOP_WORD_DEFAULT  addi x0,x0,0, returned on fetches that carry no RAM word
//   word_addr_ok()    byte address is word aligned and inside a 2**depth_log2-word RAM
//   rotl1()           rotate-left-by-one used by the image checksum
package inst_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

    // Word index is byte_addr[depth_log2+1:2]; everything above it must be zero
    // and the two byte-offset bits must be clear.
    function automatic logic word_addr_ok(input logic [31:0] byte_addr,
                                          input int unsigned depth_log2);
        return (byte_addr[1:0] == 2'b00) && ((byte_addr >> (depth_log2 + 2)) == 32'd0);
    endfunction

    function automatic logic [31:0] rotl1(input logic [31:0] value);
        return {value[30:0], value[31]};
    endfunction

endpackage

// File: rtl/inst_mem_loader_if.sv
// Interface: inst_mem_loader_if
// Boot-stream and fetch signals between the PC manager / core (master) and
// the instruction-memory loader (slave).
//   load_active  stream active (PC manager pc_override)
//   load_addr    byte address of the streamed word
//   load_data    streamed instruction word
//   fetch_en     fetch request this cycle
//   fetch_addr   byte PC of the fetch
//   fetch_data   fetched word, valid the cycle after the request
//   fetch_valid  fetch_data holds a real RAM word
//   fetch_err    misaligned or out-of-range fetch
interface inst_mem_loader_if;

    logic        load_active;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        fetch_en;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_data;
    logic        fetch_valid;
    logic        fetch_err;

    modport master (
        output load_active, load_addr, load_data, fetch_en, fetch_addr,
        input  fetch_data, fetch_valid, fetch_err
    );

    modport slave (
        input  load_active, load_addr, load_data, fetch_en, fetch_addr,
        output fetch_data, fetch_valid, fetch_err
    );

endinterface

// File: rtl/imem_ram.sv
// Module: imem_ram
// Simple dual-port RAM, 2**DEPTH_LOG2 x WIDTH, one synchronous write port and
// one synchronous read port. Contents are never reset; rd_data holds while
// rd_en is low.
//   clk      clock
//   wr_en    write enable
//   wr_addr  write word index
//   wr_data  write data
//   rd_en    read enable
//   rd_addr  read word index
//   rd_data  registered read data
module imem_ram #(
    parameter int unsigned DEPTH_LOG2 = 9,
    parameter int unsigned WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Module: inst_mem_loader
// Receiving end of the boot copy stream. Streamed words are written into
// instruction RAM while load_active is high; after the stream ends and one
// drain cycle passes the image is committed (ready=1) and fetches return RAM
// words with 1-cycle latency. Before commit, fetches return NOP_WORD.
// Optional feature macro: INST_MEM_CHECKSUM_EN (image checksum; otherwise 0).
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous, active-high
//   bus           inst_mem_loader_if.slave: load stream + fetch request/response
//   ready         image committed, core may run
//   words_loaded  distinct words written in the current load (saturating)
//   load_err      sticky: bad streamed address seen in the current load
//   checksum      image checksum (INST_MEM_CHECKSUM_EN only, else 0)
module inst_mem_loader
    import inst_mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 9,
    parameter logic [31:0] NOP_WORD   = NOP_WORD_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    inst_mem_loader_if.slave      bus,
    output logic                  ready,
    output logic [DEPTH_LOG2:0]   words_loaded,
    output logic                  load_err,
    output logic [31:0]           checksum
);

    localparam logic [DEPTH_LOG2:0] WORDS_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

    state_t                  state;
    logic                    have_last;
    logic [DEPTH_LOG2-1:0]   last_idx;
    logic                    fetch_valid;
    logic                    fetch_err;
    logic [31:0]             ram_rd_data;

    logic                    load_ok;
    logic [DEPTH_LOG2-1:0]   load_idx;
    logic                    load_start;
    logic                    load_sample;
    logic                    wr_en;
    logic                    counted;
    logic                    fetch_ok;
    logic                    rd_en;

    assign load_ok  = word_addr_ok(bus.load_addr, DEPTH_LOG2);
    assign load_idx = bus.load_addr[DEPTH_LOG2+1:2];

    // The edge that enters LOAD (from IDLE or RUN) is itself a sampled write.
    assign load_start  = bus.load_active && ((state == IDLE) || (state == RUN));
    assign load_sample = bus.load_active && (state == LOAD);
    assign wr_en       = bus.load_active && load_ok && (state != DRAIN);

    // A write counts when it starts a load, is the first good one, or moves
    // to a new index; repeated samples of the same address only rewrite.
    assign counted = wr_en && (load_start || !have_last || (load_idx != last_idx));

    assign fetch_ok = word_addr_ok(bus.fetch_addr, DEPTH_LOG2);
    assign rd_en    = bus.fetch_en && (state == RUN) && fetch_ok;

    imem_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (32)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (load_idx),
        .wr_data (bus.load_data),
        .rd_en   (rd_en),
        .rd_addr (bus.fetch_addr[DEPTH_LOG2+1:2]),
        .rd_data (ram_rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ready        <= 1'b0;
            words_loaded <= '0;
            load_err     <= 1'b0;
            have_last    <= 1'b0;
            last_idx     <= '0;
            fetch_valid  <= 1'b0;
            fetch_err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.load_active) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (!bus.load_active) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state <= RUN;
                    ready <= 1'b1;
                end
                RUN: begin
                    if (bus.load_active) begin
                        state <= LOAD;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                end
            endcase

            if (load_start) begin
                words_loaded <= {{DEPTH_LOG2{1'b0}}, wr_en};
                load_err     <= !load_ok;
                have_last    <= load_ok;
            end else if (load_sample) begin
                if (!load_ok) begin
                    load_err <= 1'b1;
                end
                if (wr_en) begin
                    have_last <= 1'b1;
                end
                if (counted && (words_loaded != WORDS_MAX)) begin
                    words_loaded <= words_loaded + 1'b1;
                end
            end

            if (wr_en) begin
                last_idx <= load_idx;
            end

            if (bus.fetch_en) begin
                if (state != RUN) begin
                    fetch_valid <= 1'b0;
                    fetch_err   <= 1'b0;
                end else if (!fetch_ok) begin
                    fetch_valid <= 1'b0;
                    fetch_err   <= 1'b1;
                end else begin
                    fetch_valid <= 1'b1;
                    fetch_err   <= 1'b0;
                end
            end
        end
    end

    // The RAM read register and fetch_valid update on the same edge and both
    // hold while fetch_en is low, so this mux behaves as a registered output.
    assign bus.fetch_data  = fetch_valid ? ram_rd_data : NOP_WORD;
    assign bus.fetch_valid = fetch_valid;
    assign bus.fetch_err   = fetch_err;

`ifdef INST_MEM_CHECKSUM_EN
    logic [31:0] cks;
    logic [31:0] cks_base;

    assign cks_base = load_start ? 32'h0 : cks;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cks <= '0;
        end else if (counted) begin
            cks <= rotl1(cks_base) ^ bus.load_data;
        end else if (load_start) begin
            cks <= '0;
        end
    end

    assign checksum = cks;
`else
    assign checksum = '0;
`endif

endmodule
